// File: rtl/dma_regs_pkg.sv
// Shared definitions for the MM2S DMA register model: register offsets,
// bit positions, AXI response codes, FSM state encoding and an offset
// decoder. The master-side control blocks import the same offsets.
package dma_regs_pkg;

  localparam logic [31:0] OFF_DMACR  = 32'h00;
  localparam logic [31:0] OFF_DMASR  = 32'h04;
  localparam logic [31:0] OFF_SA     = 32'h18;
  localparam logic [31:0] OFF_SA_MSB = 32'h1C;
  localparam logic [31:0] OFF_LENGTH = 32'h28;

  // DMACR bits
  localparam int BIT_RS        = 0;
  localparam int BIT_RESET     = 2;
  localparam int BIT_IOC_IRQEN = 12;
  // DMASR bits
  localparam int BIT_HALTED    = 0;
  localparam int BIT_IDLE      = 1;
  localparam int BIT_IOC_IRQ   = 12;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_BUSY = 2'd2
  } dma_state_e;

  typedef enum logic [2:0] {
    REG_DMACR  = 3'd0,
    REG_DMASR  = 3'd1,
    REG_SA     = 3'd2,
    REG_SA_MSB = 3'd3,
    REG_LENGTH = 3'd4,
    REG_NONE   = 3'd7
  } reg_sel_e;

  // Low two address bits are don't-care; every other bit must match.
  function automatic reg_sel_e decode_offset(input logic [31:0] addr);
    reg_sel_e sel;
    case (addr & ~32'h3)
      OFF_DMACR:  sel = REG_DMACR;
      OFF_DMASR:  sel = REG_DMASR;
      OFF_SA:     sel = REG_SA;
      OFF_SA_MSB: sel = REG_SA_MSB;
      OFF_LENGTH: sel = REG_LENGTH;
      default:    sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/dma_mm2s_lite_regs_if.sv
// AXI4-Lite bus bundle between a control master and the MM2S register model.
// master: drives AW/W/AR and bready/rready; slave: drives ready/B/R returns.
interface dma_mm2s_lite_regs_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, output awready,
    input wdata, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_slave_if.sv
// AXI4-Lite responder front end: one-entry AW and W holding registers,
// B/R response registers and offset decode.
// Ports: clk, rst (async active-low), bus (slave modport),
//        wr_en/wr_sel/wr_data: single-cycle register write commit,
//        rd_sel: decode of the live araddr, rd_data: register value for it.
module axi_lite_slave_if
  import dma_regs_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  dma_mm2s_lite_regs_if.slave bus,
  output logic                wr_en,
  output reg_sel_e            wr_sel,
  output logic [31:0]         wr_data,
  output reg_sel_e            rd_sel,
  input  logic [31:0]         rd_data
);

  logic              aw_full_q, aw_full_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic              w_full_q, w_full_d;
  logic [31:0]       w_data_q, w_data_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic awready, wready, arready;

  assign awready = ~aw_full_q & ~bvalid_q;
  assign wready  = ~w_full_q & ~bvalid_q;
  assign arready = ~rvalid_q;

  assign bus.awready = awready;
  assign bus.wready  = wready;
  assign bus.arready = arready;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;

  // Entries stay full until the B handshake, so bvalid_q gates a repeat commit.
  assign wr_en   = aw_full_q & w_full_q & ~bvalid_q;
  assign wr_sel  = decode_offset(32'(aw_addr_q));
  assign wr_data = w_data_q;
  assign rd_sel  = decode_offset(32'(bus.araddr));

  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    if (bus.awvalid && awready) begin
      aw_full_d = 1'b1;
      aw_addr_d = bus.awaddr;
    end
    if (bus.wvalid && wready) begin
      w_full_d = 1'b1;
      w_data_d = bus.wdata;
    end
    if (wr_en) begin
      bvalid_d = 1'b1;
      bresp_d  = (wr_sel == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
    end
    if (bvalid_q && bus.bready) begin
      bvalid_d  = 1'b0;
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end

    // rd_data reflects register state before any write committing this edge.
    if (bus.arvalid && arready) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data;
      rresp_d  = (rd_sel == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
    end else if (rvalid_q && bus.rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule

// File: rtl/dma_mm2s_lite_regs.sv
// MM2S DMA register model: DMACR/DMASR/SA/SA_MSB/LENGTH behind AXI4-Lite,
// issues one command per qualifying LENGTH write and raises a completion irq.
// Ports: clk, rst (async active-low), s_axi_lite (slave modport),
//        cmd_addr/cmd_len/cmd_valid/cmd_ready: data mover command,
//        xfer_done: completion pulse, mm2s_introut: level interrupt.
//
// state   | meaning
// IDLE    | no transfer; LENGTH/SA/SA_MSB writable
// CMD     | cmd_valid high, waiting for cmd_ready
// BUSY    | command accepted, waiting for xfer_done
module dma_mm2s_lite_regs
  import dma_regs_pkg::*;
#(
  parameter int LEN_W  = 26,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  dma_mm2s_lite_regs_if.slave s_axi_lite,
  output logic [63:0]         cmd_addr,
  output logic [LEN_W-1:0]    cmd_len,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  input  logic                xfer_done,
  output logic                mm2s_introut
);

  dma_state_e       state_q, state_d;
  logic             rs_q, rs_d;
  logic             ien_q, ien_d;
  logic             irq_q, irq_d;
  logic [31:0]      sa_q, sa_d;
  logic [31:0]      sa_msb_q, sa_msb_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             introut_q, introut_d;

  logic        wr_en;
  reg_sel_e    wr_sel;
  logic [31:0] wr_data;
  reg_sel_e    rd_sel;
  logic [31:0] rd_data;
  logic        idle;
  logic        soft_rst;

  axi_lite_slave_if #(.ADDR_W(ADDR_W)) u_slave (
    .clk     (clk),
    .rst     (rst),
    .bus     (s_axi_lite),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_data (wr_data),
    .rd_sel  (rd_sel),
    .rd_data (rd_data)
  );

  assign idle     = (state_q == ST_IDLE);
  assign soft_rst = wr_en && (wr_sel == REG_DMACR) && wr_data[BIT_RESET];

  always_comb begin
    state_d  = state_q;
    rs_d     = rs_q;
    ien_d    = ien_q;
    irq_d    = irq_q;
    sa_d     = sa_q;
    sa_msb_d = sa_msb_q;
    len_d    = len_q;

    if (wr_en) begin
      case (wr_sel)
        REG_DMACR: begin
          rs_d  = wr_data[BIT_RS];
          ien_d = wr_data[BIT_IOC_IRQEN];
        end
        REG_DMASR:  if (wr_data[BIT_IOC_IRQ]) irq_d = 1'b0;
        REG_SA:     if (idle) sa_d = wr_data;
        REG_SA_MSB: if (idle) sa_msb_d = wr_data;
        REG_LENGTH: begin
          if (idle) begin
            len_d = wr_data[LEN_W-1:0];
            if (rs_q && (wr_data[LEN_W-1:0] != '0)) state_d = ST_CMD;
          end
        end
        default: ;
      endcase
    end

    // Evaluated after the W1C so a same-cycle completion keeps the irq set.
    case (state_q)
      ST_CMD:  if (cmd_ready) state_d = ST_BUSY;
      ST_BUSY: begin
        if (xfer_done) begin
          state_d = ST_IDLE;
          irq_d   = 1'b1;
        end
      end
      default: ;
    endcase

    if (soft_rst) begin
      state_d  = ST_IDLE;
      rs_d     = 1'b0;
      ien_d    = 1'b0;
      irq_d    = 1'b0;
      sa_d     = '0;
      sa_msb_d = '0;
      len_d    = '0;
    end

    introut_d = irq_d & ien_d;
  end

  always_comb begin
    rd_data = '0;
    case (rd_sel)
      REG_DMACR: begin
        rd_data[BIT_RS]        = rs_q;
        rd_data[BIT_IOC_IRQEN] = ien_q;
      end
      REG_DMASR: begin
        rd_data[BIT_HALTED]  = ~rs_q & idle;
        rd_data[BIT_IDLE]    = idle;
        rd_data[BIT_IOC_IRQ] = irq_q;
      end
      REG_SA:     rd_data = sa_q;
      REG_SA_MSB: rd_data = sa_msb_q;
      REG_LENGTH: rd_data[LEN_W-1:0] = len_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      rs_q      <= 1'b0;
      ien_q     <= 1'b0;
      irq_q     <= 1'b0;
      sa_q      <= '0;
      sa_msb_q  <= '0;
      len_q     <= '0;
      introut_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rs_q      <= rs_d;
      ien_q     <= ien_d;
      irq_q     <= irq_d;
      sa_q      <= sa_d;
      sa_msb_q  <= sa_msb_d;
      len_q     <= len_d;
      introut_q <= introut_d;
    end
  end

  assign cmd_addr     = {sa_msb_q, sa_q};
  assign cmd_len      = len_q;
  assign cmd_valid    = (state_q == ST_CMD);
  assign mm2s_introut = introut_q;

endmodule

// File: tb/tb_dma_mm2s_lite_regs.sv
module tb_dma_mm2s_lite_regs;

  localparam int LEN_W  = 26;
  localparam int ADDR_W = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [63:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             xfer_done;
  logic             mm2s_introut;

  int compared = 0;
  int errors   = 0;

  always #5 clk = ~clk;

  dma_mm2s_lite_regs_if #(.ADDR_W(ADDR_W)) axi ();

  dma_mm2s_lite_regs #(.LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axi_lite   (axi),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .xfer_done    (xfer_done),
    .mm2s_introut (mm2s_introut)
  );

  // Transaction-level reference model of the register set.
  bit          m_rs, m_ien, m_irq;
  logic [31:0] m_sa, m_sa_msb;
  logic [25:0] m_len;
  int          m_phase;  // 0 no transfer, 1 awaiting data mover, 2 transferring

  function automatic void m_reset();
    m_rs = 0; m_ien = 0; m_irq = 0; m_sa = 0; m_sa_msb = 0; m_len = 0; m_phase = 0;
  endfunction

  function automatic bit m_mapped(input logic [9:0] a);
    logic [9:0] o;
    o = {a[9:2], 2'b00};
    return (o == 10'h000) || (o == 10'h004) || (o == 10'h018) || (o == 10'h01C) || (o == 10'h028);
  endfunction

  function automatic void m_write(input logic [9:0] a, input logic [31:0] d);
    logic [9:0] o;
    o = {a[9:2], 2'b00};
    if (o == 10'h000) begin
      if (d[2]) m_reset();
      else begin m_rs = d[0]; m_ien = d[12]; end
    end else if (o == 10'h004) begin
      if (d[12]) m_irq = 0;
    end else if (o == 10'h018) begin
      if (m_phase == 0) m_sa = d;
    end else if (o == 10'h01C) begin
      if (m_phase == 0) m_sa_msb = d;
    end else if (o == 10'h028) begin
      if (m_phase == 0) begin
        m_len = d[25:0];
        if (m_len != 0 && m_rs) m_phase = 1;
      end
    end
  endfunction

  function automatic logic [31:0] m_read(input logic [9:0] a);
    logic [9:0] o;
    o = {a[9:2], 2'b00};
    if (o == 10'h000) return (32'(m_ien) << 12) | 32'(m_rs);
    if (o == 10'h004) return (32'(m_irq) << 12) | (32'(m_phase == 0) << 1) | 32'(!m_rs && m_phase == 0);
    if (o == 10'h018) return m_sa;
    if (o == 10'h01C) return m_sa_msb;
    if (o == 10'h028) return {6'd0, m_len};
    return 32'd0;
  endfunction

  // Bus tasks: start and end at 1 time unit after a rising edge.
  task automatic axi_write(input logic [9:0] a, input logic [31:0] d,
                           output logic [1:0] resp, output logic cv_at_b);
    bit aw_done, w_done, aw_hs, w_hs, got;
    aw_done = 0; w_done = 0; got = 0; resp = 2'bxx; cv_at_b = 1'bx;
    axi.awaddr = a; axi.awvalid = 1; axi.wdata = d; axi.wvalid = 1; axi.bready = 1;
    for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
      @(negedge clk);
      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid && axi.wready;
      @(posedge clk); #1;
      if (aw_hs) begin aw_done = 1; axi.awvalid = 0; end
      if (w_hs)  begin w_done = 1;  axi.wvalid = 0;  end
    end
    axi.awvalid = 0; axi.wvalid = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (axi.bvalid) begin got = 1; resp = axi.bresp; cv_at_b = cmd_valid; end
      @(posedge clk); #1;
    end
    axi.bready = 0;
    if (!got) begin
      compared++; errors++;
      $display("FAIL write_timeout addr=%h: no B response within bound", a);
    end
  endtask

  task automatic axi_read(input logic [9:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit hs, got;
    hs = 0; got = 0; d = 'x; resp = 2'bxx;
    axi.araddr = a; axi.arvalid = 1; axi.rready = 1;
    for (int i = 0; i < 20 && !hs; i++) begin
      @(negedge clk);
      hs = axi.arready;
      @(posedge clk); #1;
    end
    axi.arvalid = 0;
    for (int i = 0; i < 20 && hs && !got; i++) begin
      @(negedge clk);
      if (axi.rvalid) begin got = 1; d = axi.rdata; resp = axi.rresp; end
      @(posedge clk); #1;
    end
    axi.rready = 0;
    if (!got) begin
      compared++; errors++;
      $display("FAIL read_timeout addr=%h: no R response within bound", a);
    end
  endtask

  task automatic pulse_cmd_ready();
    cmd_ready = 1; @(posedge clk); #1; cmd_ready = 0;
  endtask

  task automatic pulse_xfer_done();
    xfer_done = 1; @(posedge clk); #1; xfer_done = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    logic [9:0]  addrs [5] = '{10'h000, 10'h004, 10'h018, 10'h01C, 10'h028};
    logic [31:0] exps  [5] = '{32'h0, 32'h3, 32'h0, 32'h0, 32'h0};
    #2;
    compared++;
    if ({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, cmd_valid, mm2s_introut} !== 7'b1110000) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 1110000 (awr,wr,arr,bv,rv,cv,irq)",
               {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, cmd_valid, mm2s_introut});
    end
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      axi_read(addrs[i], d, r);
      compared++;
      if (d !== exps[i] || r !== 2'b00) begin
        errors++;
        $display("FAIL reset_read[%h]: got %h/%b required %h/00", addrs[i], d, r, exps[i]);
      end
    end
  endtask

  task automatic test_launch();
    logic [1:0] r; logic cv; logic [31:0] d;
    logic [9:0]  addrs [4] = '{10'h000, 10'h018, 10'h01C, 10'h028};
    logic [31:0] vals  [4] = '{32'h0000_1001, 32'h1000_0000, 32'h0000_0002, 32'h0000_0400};
    for (int i = 0; i < 4; i++) begin
      axi_write(addrs[i], vals[i], r, cv);
      compared++;
      if (r !== 2'b00 || cv !== (i == 3)) begin
        errors++;
        $display("FAIL launch_write[%0d]: bresp=%b cmd_valid=%b required 00/%b", i, r, cv, (i == 3));
      end
    end
    @(negedge clk);
    compared++;
    if (cmd_addr !== 64'h0000_0002_1000_0000 || cmd_len !== 26'h400 || cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL launch_cmd: got addr=%h len=%h v=%b required 0000000210000000/400/1", cmd_addr, cmd_len, cmd_valid);
    end
    @(posedge clk); #1;
    pulse_cmd_ready();
    @(negedge clk);
    compared++;
    if (cmd_valid !== 1'b0) begin
      errors++; $display("FAIL launch_accept: cmd_valid=%b required 0", cmd_valid);
    end
    @(posedge clk); #1;
    axi_read(10'h004, d, r);
    compared++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL busy_dmasr: got %h required 00000000", d);
    end
  endtask

  task automatic test_busy_unmapped();
    logic [1:0] r; logic cv; logic [31:0] d;
    axi_write(10'h018, 32'hDEAD_0000, r, cv);
    compared++;
    if (r !== 2'b00) begin errors++; $display("FAIL busy_sa_bresp: got %b required 00", r); end
    axi_read(10'h018, d, r);
    compared++;
    if (d !== 32'h1000_0000) begin errors++; $display("FAIL busy_sa_read: got %h required 10000000", d); end
    axi_read(10'h03C, d, r);
    compared++;
    if (d !== 32'h0 || r !== 2'b10) begin
      errors++; $display("FAIL unmapped_read: got %h/%b required 00000000/10", d, r);
    end
    axi_write(10'h03C, 32'hFFFF_FFFF, r, cv);
    compared++;
    if (r !== 2'b10) begin errors++; $display("FAIL unmapped_write: got %b required 10", r); end
  endtask

  task automatic test_completion();
    logic [1:0] r; logic cv; logic [31:0] d;
    xfer_done = 1;
    @(negedge clk);
    compared++;
    if (mm2s_introut !== 1'b0) begin errors++; $display("FAIL irq_early: got %b required 0", mm2s_introut); end
    @(posedge clk); #1; xfer_done = 0;
    @(negedge clk);
    compared++;
    if (mm2s_introut !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b required 1", mm2s_introut); end
    @(posedge clk); #1;
    axi_read(10'h004, d, r);
    compared++;
    if (d !== 32'h0000_1002) begin errors++; $display("FAIL done_dmasr: got %h required 00001002", d); end
    axi_write(10'h004, 32'h0000_1000, r, cv);
    @(negedge clk);
    compared++;
    if (mm2s_introut !== 1'b0) begin errors++; $display("FAIL irq_w1c: got %b required 0", mm2s_introut); end
    @(posedge clk); #1;
    axi_read(10'h004, d, r);
    compared++;
    if (d !== 32'h0000_0002) begin errors++; $display("FAIL w1c_dmasr: got %h required 00000002", d); end
  endtask

  task automatic test_blocked();
    logic [1:0] r; logic cv; logic [31:0] d;
    axi_write(10'h028, 32'h0, r, cv);
    compared++;
    if (cv !== 1'b0) begin errors++; $display("FAIL blocked_zero: cmd_valid=%b required 0", cv); end
    axi_write(10'h000, 32'h0000_1000, r, cv);
    axi_write(10'h028, 32'h80, r, cv);
    compared++;
    if (cv !== 1'b0) begin errors++; $display("FAIL blocked_rs0: cmd_valid=%b required 0", cv); end
    axi_read(10'h028, d, r);
    compared++;
    if (d !== 32'h80) begin errors++; $display("FAIL blocked_len: got %h required 00000080", d); end
    axi_read(10'h004, d, r);
    compared++;
    if (d !== 32'h3) begin errors++; $display("FAIL blocked_dmasr: got %h required 00000003", d); end
  endtask

  task automatic test_write_ordering();
    logic [1:0] r; logic [31:0] d; bit got;
    axi.bready = 0;
    axi.wdata = 32'h1111_0000; axi.wvalid = 1;
    @(posedge clk); #1; axi.wvalid = 0;
    @(negedge clk);
    compared++;
    if (axi.wready !== 1'b0) begin errors++; $display("FAIL order_wfull: wready=%b required 0", axi.wready); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    axi.awaddr = 10'h018; axi.awvalid = 1;
    @(posedge clk); #1; axi.awvalid = 0;
    @(negedge clk);
    compared++;
    if (axi.bvalid !== 1'b0) begin errors++; $display("FAIL order_b_early: bvalid=%b required 0", axi.bvalid); end
    @(posedge clk); #1;
    axi.awaddr = 10'h018; axi.awvalid = 1; axi.wdata = 32'h2222_0000; axi.wvalid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      compared++;
      if ({axi.bvalid, axi.awready, axi.wready} !== 3'b100) begin
        errors++;
        $display("FAIL order_hold[%0d]: bvalid,awready,wready=%b required 100", i, {axi.bvalid, axi.awready, axi.wready});
      end
      @(posedge clk); #1;
    end
    axi_read(10'h018, d, r);
    compared++;
    if (d !== 32'h1111_0000 || axi.bvalid !== 1'b1) begin
      errors++; $display("FAIL order_first: SA=%h bvalid=%b required 11110000/1", d, axi.bvalid);
    end
    axi.bready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    compared++;
    if (axi.awready !== 1'b1) begin errors++; $display("FAIL order_reopen: awready=%b required 1", axi.awready); end
    @(posedge clk); #1;
    axi.awvalid = 0; axi.wvalid = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = axi.bvalid;
      @(posedge clk); #1;
    end
    axi.bready = 0;
    compared++;
    if (!got) begin errors++; $display("FAIL order_second_b: bvalid=0 required 1 within bound"); end
    axi_read(10'h018, d, r);
    compared++;
    if (d !== 32'h2222_0000) begin errors++; $display("FAIL order_second: SA=%h required 22220000", d); end
  endtask

  task automatic test_irq_set_wins();
    logic [1:0] r; logic cv; logic [31:0] d;
    axi_write(10'h000, 32'h0000_1001, r, cv);
    axi_write(10'h028, 32'h10, r, cv);
    pulse_cmd_ready();
    axi.awaddr = 10'h004; axi.wdata = 32'h0000_1000; axi.awvalid = 1; axi.wvalid = 1; axi.bready = 1;
    @(posedge clk); #1;
    axi.awvalid = 0; axi.wvalid = 0; xfer_done = 1;
    @(posedge clk); #1;
    xfer_done = 0;
    @(negedge clk);
    compared++;
    if (mm2s_introut !== 1'b1 || axi.bvalid !== 1'b1) begin
      errors++; $display("FAIL set_wins_irq: introut=%b bvalid=%b required 1/1", mm2s_introut, axi.bvalid);
    end
    @(posedge clk); #1; axi.bready = 0;
    axi_read(10'h004, d, r);
    compared++;
    if (d !== 32'h0000_1002) begin errors++; $display("FAIL set_wins_dmasr: got %h required 00001002", d); end
    axi_write(10'h004, 32'h0000_1000, r, cv);
  endtask

  task automatic test_soft_reset();
    logic [1:0] r; logic cv; logic [31:0] d;
    logic [9:0]  addrs [5] = '{10'h000, 10'h004, 10'h018, 10'h01C, 10'h028};
    logic [31:0] exps  [5] = '{32'h0, 32'h3, 32'h0, 32'h0, 32'h0};
    axi_write(10'h028, 32'h20, r, cv);
    compared++;
    if (cv !== 1'b1) begin errors++; $display("FAIL soft_launch: cmd_valid=%b required 1", cv); end
    axi_write(10'h000, 32'h4, r, cv);
    compared++;
    if (r !== 2'b00 || cv !== 1'b0) begin
      errors++; $display("FAIL soft_reset_b: bresp=%b cmd_valid=%b required 00/0", r, cv);
    end
    for (int i = 0; i < 5; i++) begin
      axi_read(addrs[i], d, r);
      compared++;
      if (d !== exps[i]) begin errors++; $display("FAIL soft_read[%h]: got %h required %h", addrs[i], d, exps[i]); end
    end
  endtask

  task automatic test_random();
    logic [9:0]  mapped   [5]  = '{10'h000, 10'h004, 10'h018, 10'h01C, 10'h028};
    logic [9:0]  unmapped [10] = '{10'h008, 10'h00C, 10'h010, 10'h014, 10'h020,
                                   10'h024, 10'h02C, 10'h03C, 10'h100, 10'h3F8};
    logic [9:0] a; logic [31:0] d, e; logic [1:0] r, er; logic cv; int op;
    m_reset();
    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 5) == 0) a = unmapped[$urandom_range(0, 9)];
      else a = mapped[$urandom_range(0, 4)];
      a = a | 10'($urandom_range(0, 3));
      if (op <= 4) begin
        d = $urandom;
        if ({a[9:2], 2'b00} == 10'h000 && $urandom_range(0, 7) != 0) d[2] = 1'b0;
        if ({a[9:2], 2'b00} == 10'h028 && $urandom_range(0, 3) == 0) d[25:0] = '0;
        er = m_mapped(a) ? 2'b00 : 2'b10;
        m_write(a, d);
        axi_write(a, d, r, cv);
        compared++;
        if (r !== er) begin errors++; $display("FAIL rnd_bresp[%0d] addr=%h: got %b required %b", n, a, r, er); end
      end else if (op <= 7) begin
        e  = m_read(a);
        er = m_mapped(a) ? 2'b00 : 2'b10;
        axi_read(a, d, r);
        compared++;
        if (d !== e || r !== er) begin
          errors++; $display("FAIL rnd_read[%0d] addr=%h: got %h/%b required %h/%b", n, a, d, r, e, er);
        end
      end else if (op == 8) begin
        pulse_cmd_ready();
        if (m_phase == 1) m_phase = 2;
      end else begin
        pulse_xfer_done();
        if (m_phase == 2) begin m_phase = 0; m_irq = 1; end
      end
      @(negedge clk);
      compared++;
      if (cmd_valid !== (m_phase == 1) || mm2s_introut !== (m_irq && m_ien)) begin
        errors++;
        $display("FAIL rnd_status[%0d]: cmd_valid=%b introut=%b required %b/%b", n, cmd_valid, mm2s_introut,
                 (m_phase == 1), (m_irq && m_ien));
      end
      if (m_phase != 0) begin
        compared++;
        if (cmd_addr !== {m_sa_msb, m_sa} || cmd_len !== m_len) begin
          errors++;
          $display("FAIL rnd_cmd[%0d]: got %h/%h required %h/%h", n, cmd_addr, cmd_len, {m_sa_msb, m_sa}, m_len);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    axi.awaddr = 10'h018; axi.wdata = 32'h5; axi.awvalid = 1; axi.wvalid = 1; axi.bready = 0;
    axi.araddr = 10'h018; axi.arvalid = 1; axi.rready = 0;
    @(posedge clk); #1;
    axi.awvalid = 0; axi.wvalid = 0; axi.arvalid = 0;
    @(posedge clk); #1;
    @(negedge clk);
    compared++;
    if (axi.bvalid !== 1'b1 || axi.rvalid !== 1'b1) begin
      errors++; $display("FAIL async_pre: bvalid=%b rvalid=%b required 1/1", axi.bvalid, axi.rvalid);
    end
    #2 rst = 0;
    #1;
    compared++;
    if ({axi.bvalid, axi.rvalid, axi.awready, axi.wready, axi.arready} !== 5'b00111) begin
      errors++;
      $display("FAIL async_reset: bv,rv,awr,wr,arr=%b required 00111",
               {axi.bvalid, axi.rvalid, axi.awready, axi.wready, axi.arready});
    end
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    axi.awaddr = '0; axi.awvalid = 0; axi.wdata = '0; axi.wvalid = 0; axi.bready = 0;
    axi.araddr = '0; axi.arvalid = 0; axi.rready = 0;
    cmd_ready = 0; xfer_done = 0;
    rst = 0;
    repeat (2) @(posedge clk);
    test_reset();
    test_launch();
    test_busy_unmapped();
    test_completion();
    test_blocked();
    test_write_ordering();
    test_irq_set_wins();
    test_soft_reset();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
